// File: rtl/foo_slot_tracker.sv
// foo_slot_tracker: per-slot lifecycle tracker for up to 16 foo slots.
// Each slot moves through INACTIVE -> PENDING -> ACTIVE -> DRAIN -> INACTIVE.
// States are published as packed 2-bit fields, both registered and next-state.
module foo_slot_tracker #(
    parameter int NUM_SLOTS    = 7,
    parameter int WORD_W       = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_alloc_valid,
    output logic              o_alloc_ready,
    output logic [3:0]        o_alloc_slot,
    input  logic              i_start_valid,
    input  logic [3:0]        i_start_slot,
    input  logic              i_done_valid,
    input  logic [3:0]        i_done_slot,
    output logic [WORD_W-1:0] o_foo_current,
    output logic [WORD_W-1:0] o_foo_next,
    output logic              o_err
);

    typedef enum logic [1:0] {
        SLOT_INACTIVE = 2'b00,
        SLOT_PENDING  = 2'b01,
        SLOT_ACTIVE   = 2'b10,
        SLOT_DRAIN    = 2'b11
    } slotState_e;

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    slotState_e       slotState_q [NUM_SLOTS];
    slotState_e       slotState_d [NUM_SLOTS];
    logic [CNT_W-1:0] drainCnt_q  [NUM_SLOTS];
    logic [CNT_W-1:0] drainCnt_d  [NUM_SLOTS];
    logic             err_q;
    logic             err_d;

    logic             allocReady;
    logic [3:0]       allocSlot;
    logic             allocFire;
    logic             startLegal;
    logic             doneLegal;
    logic [WORD_W-1:0] fooCurrent;
    logic [WORD_W-1:0] fooNext;

    // Pick the lowest-index INACTIVE slot; a slot still in DRAIN is not a candidate.
    always_comb begin
        allocReady = 1'b0;
        allocSlot  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slotState_q[i] == SLOT_INACTIVE) begin
                allocReady = 1'b1;
                allocSlot  = 4'(i);
            end
        end
    end

    assign allocFire = i_alloc_valid & allocReady;

    // Per-slot next state from registered state; events matching no legal slot flag an error.
    always_comb begin
        startLegal = 1'b0;
        doneLegal  = 1'b0;
        fooNext    = '0;
        fooCurrent = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slotState_d[i] = slotState_q[i];
            drainCnt_d[i]  = drainCnt_q[i];
            case (slotState_q[i])
                SLOT_INACTIVE: begin
                    if (allocFire && (allocSlot == 4'(i))) begin
                        slotState_d[i] = SLOT_PENDING;
                    end
                end
                SLOT_PENDING: begin
                    if (i_start_valid && (i_start_slot == 4'(i))) begin
                        slotState_d[i] = SLOT_ACTIVE;
                        startLegal     = 1'b1;
                    end
                end
                SLOT_ACTIVE: begin
                    if (i_done_valid && (i_done_slot == 4'(i))) begin
                        slotState_d[i] = SLOT_DRAIN;
                        drainCnt_d[i]  = DRAIN_LOAD;
                        doneLegal      = 1'b1;
                    end
                end
                default: begin
                    if (drainCnt_q[i] == '0) begin
                        slotState_d[i] = SLOT_INACTIVE;
                    end else begin
                        drainCnt_d[i] = drainCnt_q[i] - 1'b1;
                    end
                end
            endcase
            fooNext[2*i +: 2]    = slotState_d[i];
            fooCurrent[2*i +: 2] = slotState_q[i];
        end
        if (!i_rst_n) begin
            fooNext = '0;
        end
        err_d = i_rst_n & ((i_start_valid & ~startLegal) | (i_done_valid & ~doneLegal));
    end

    // Slot state, drain counters and error pulse register; reset forces everything idle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slotState_q[i] <= SLOT_INACTIVE;
                drainCnt_q[i]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slotState_q[i] <= slotState_d[i];
                drainCnt_q[i]  <= drainCnt_d[i];
            end
            err_q <= err_d;
        end
    end

    assign o_alloc_ready = allocReady;
    assign o_alloc_slot  = allocSlot;
    assign o_foo_current = fooCurrent;
    assign o_foo_next    = fooNext;
    assign o_err         = err_q;

endmodule

// File: tb/tb_foo_slot_tracker.sv
// Directed testbench for foo_slot_tracker with default parameters
// (7 slots, 32-bit words, 4 drain cycles).
module tb_foo_slot_tracker;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_alloc_valid;
    logic        o_alloc_ready;
    logic [3:0]  o_alloc_slot;
    logic        i_start_valid;
    logic [3:0]  i_start_slot;
    logic        i_done_valid;
    logic [3:0]  i_done_slot;
    logic [31:0] o_foo_current;
    logic [31:0] o_foo_next;
    logic        o_err;

    int total;
    int bad;

    foo_slot_tracker #(
        .NUM_SLOTS(7),
        .WORD_W(32),
        .DRAIN_CYCLES(4)
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_alloc_valid(i_alloc_valid),
        .o_alloc_ready(o_alloc_ready),
        .o_alloc_slot(o_alloc_slot),
        .i_start_valid(i_start_valid),
        .i_start_slot(i_start_slot),
        .i_done_valid(i_done_valid),
        .i_done_slot(i_done_slot),
        .o_foo_current(o_foo_current),
        .o_foo_next(o_foo_next),
        .o_err(o_err)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic logic [1:0] field(input logic [31:0] word, input int idx);
        return word[2*idx +: 2];
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clearInputs();
        i_alloc_valid = 1'b0;
        i_start_valid = 1'b0;
        i_start_slot  = 4'd0;
        i_done_valid  = 1'b0;
        i_done_slot   = 4'd0;
    endtask

    task automatic doReset();
        clearInputs();
        i_rst_n = 1'b0;
        step();
        step();
        i_rst_n = 1'b1;
    endtask

    task automatic allocN(input int n);
        i_alloc_valid = 1'b1;
        for (int k = 0; k < n; k++) step();
        i_alloc_valid = 1'b0;
    endtask

    task automatic test_reset();
        clearInputs();
        i_rst_n       = 1'b0;
        step();
        i_start_valid = 1'b1;
        i_start_slot  = 4'd9;
        i_done_valid  = 1'b1;
        i_done_slot   = 4'd3;
        i_alloc_valid = 1'b1;
        #1;
        total++;
        if (o_foo_next !== 32'h0) begin
            $display("[TB] FAIL reset_next: got %h want %h", o_foo_next, 32'h0);
            bad++;
        end
        step();
        clearInputs();
        i_rst_n = 1'b1;
        #1;
        total++;
        if (o_foo_current !== 32'h0) begin
            $display("[TB] FAIL reset_current: got %h want %h", o_foo_current, 32'h0);
            bad++;
        end
        total++;
        if (o_alloc_ready !== 1'b1 || o_alloc_slot !== 4'd0) begin
            $display("[TB] FAIL reset_alloc: got ready=%b slot=%0d want ready=1 slot=0", o_alloc_ready, o_alloc_slot);
            bad++;
        end
        step();
        total++;
        if (o_err !== 1'b0 || o_foo_current !== 32'h0) begin
            $display("[TB] FAIL reset_idle: got err=%b cur=%h want err=0 cur=0", o_err, o_foo_current);
            bad++;
        end
    endtask

    task automatic test_alloc_fill();
        logic [31:0] expCur;
        doReset();
        expCur = 32'h0;
        i_alloc_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            #1;
            total++;
            if (o_alloc_ready !== 1'b1 || o_alloc_slot !== 4'(k)) begin
                $display("[TB] FAIL fill_grant%0d: got ready=%b slot=%0d want ready=1 slot=%0d", k, o_alloc_ready, o_alloc_slot, k);
                bad++;
            end
            total++;
            if (o_foo_next !== (expCur | (32'h1 << (2*k)))) begin
                $display("[TB] FAIL fill_next%0d: got %h want %h", k, o_foo_next, expCur | (32'h1 << (2*k)));
                bad++;
            end
            expCur = expCur | (32'h1 << (2*k));
            step();
        end
        total++;
        if (o_alloc_ready !== 1'b0 || o_foo_current !== 32'h0000_1555) begin
            $display("[TB] FAIL fill_full: got ready=%b cur=%h want ready=0 cur=00001555", o_alloc_ready, o_foo_current);
            bad++;
        end
        step();
        total++;
        if (o_err !== 1'b0 || o_foo_current !== 32'h0000_1555) begin
            $display("[TB] FAIL fill_wait: got err=%b cur=%h want err=0 cur=00001555", o_err, o_foo_current);
            bad++;
        end
        i_alloc_valid = 1'b0;
    endtask

    task automatic test_lifecycle();
        doReset();
        allocN(3);
        i_start_valid = 1'b1;
        i_start_slot  = 4'd2;
        #1;
        total++;
        if (field(o_foo_next, 2) !== 2'b10 || field(o_foo_current, 2) !== 2'b01) begin
            $display("[TB] FAIL life_start: got cur=%b next=%b want cur=01 next=10", field(o_foo_current, 2), field(o_foo_next, 2));
            bad++;
        end
        step();
        i_start_valid = 1'b0;
        i_done_valid  = 1'b1;
        i_done_slot   = 4'd2;
        #1;
        total++;
        if (field(o_foo_current, 2) !== 2'b10 || field(o_foo_next, 2) !== 2'b11) begin
            $display("[TB] FAIL life_done: got cur=%b next=%b want cur=10 next=11", field(o_foo_current, 2), field(o_foo_next, 2));
            bad++;
        end
        step();
        i_done_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            total++;
            if (field(o_foo_current, 2) !== 2'b11 || o_err !== 1'b0) begin
                $display("[TB] FAIL life_drain%0d: got cur=%b err=%b want cur=11 err=0", c, field(o_foo_current, 2), o_err);
                bad++;
            end
            total++;
            if (field(o_foo_next, 2) !== ((c == 3) ? 2'b00 : 2'b11)) begin
                $display("[TB] FAIL life_drain_next%0d: got %b want %b", c, field(o_foo_next, 2), (c == 3) ? 2'b00 : 2'b11);
                bad++;
            end
            step();
        end
        total++;
        if (o_foo_current !== 32'h0000_0005 || o_alloc_ready !== 1'b1 || o_alloc_slot !== 4'd2) begin
            $display("[TB] FAIL life_end: got cur=%h ready=%b slot=%0d want cur=00000005 ready=1 slot=2", o_foo_current, o_alloc_ready, o_alloc_slot);
            bad++;
        end
    endtask

    task automatic test_drain_exit_no_grant();
        doReset();
        allocN(7);
        i_start_valid = 1'b1;
        i_start_slot  = 4'd3;
        step();
        i_start_valid = 1'b0;
        i_done_valid  = 1'b1;
        i_done_slot   = 4'd3;
        step();
        i_done_valid  = 1'b0;
        i_alloc_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (o_alloc_ready !== 1'b0 || field(o_foo_current, 3) !== 2'b11) begin
                $display("[TB] FAIL exit_hold%0d: got ready=%b f3=%b want ready=0 f3=11", c, o_alloc_ready, field(o_foo_current, 3));
                bad++;
            end
            step();
        end
        #1;
        total++;
        if (field(o_foo_current, 3) !== 2'b00 || o_alloc_ready !== 1'b1 || o_alloc_slot !== 4'd3) begin
            $display("[TB] FAIL exit_free: got f3=%b ready=%b slot=%0d want f3=00 ready=1 slot=3", field(o_foo_current, 3), o_alloc_ready, o_alloc_slot);
            bad++;
        end
        total++;
        if (o_foo_next !== 32'h0000_1555) begin
            $display("[TB] FAIL exit_next: got %h want %h", o_foo_next, 32'h0000_1555);
            bad++;
        end
        step();
        i_alloc_valid = 1'b0;
        total++;
        if (o_foo_current !== 32'h0000_1555 || o_alloc_ready !== 1'b0) begin
            $display("[TB] FAIL exit_regrant: got cur=%h ready=%b want cur=00001555 ready=0", o_foo_current, o_alloc_ready);
            bad++;
        end
    endtask

    task automatic test_illegal();
        doReset();
        i_start_valid = 1'b1;
        i_start_slot  = 4'd5;
        i_done_valid  = 1'b1;
        i_done_slot   = 4'd9;
        #1;
        total++;
        if (o_foo_next !== 32'h0 || o_err !== 1'b0) begin
            $display("[TB] FAIL illegal_pre: got next=%h err=%b want next=0 err=0", o_foo_next, o_err);
            bad++;
        end
        step();
        clearInputs();
        total++;
        if (o_err !== 1'b1 || o_foo_current !== 32'h0) begin
            $display("[TB] FAIL illegal_err: got err=%b cur=%h want err=1 cur=0", o_err, o_foo_current);
            bad++;
        end
        step();
        total++;
        if (o_err !== 1'b0) begin
            $display("[TB] FAIL illegal_pulse: got err=%b want 0", o_err);
            bad++;
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        allocN(2);
        i_start_valid = 1'b1;
        i_start_slot  = 4'd1;
        step();
        i_alloc_valid = 1'b1;
        i_start_slot  = 4'd0;
        i_done_valid  = 1'b1;
        i_done_slot   = 4'd1;
        #1;
        total++;
        if (o_foo_next !== 32'h0000_001E) begin
            $display("[TB] FAIL b2b_next: got %h want %h", o_foo_next, 32'h0000_001E);
            bad++;
        end
        step();
        clearInputs();
        total++;
        if (o_foo_current !== 32'h0000_001E || o_err !== 1'b0) begin
            $display("[TB] FAIL b2b_cur: got cur=%h err=%b want cur=0000001e err=0", o_foo_current, o_err);
            bad++;
        end
        i_start_valid = 1'b1;
        i_start_slot  = 4'd0;
        i_done_valid  = 1'b1;
        i_done_slot   = 4'd0;
        step();
        clearInputs();
        total++;
        if (field(o_foo_current, 0) !== 2'b11 || o_err !== 1'b1) begin
            $display("[TB] FAIL b2b_same: got f0=%b err=%b want f0=11 err=1", field(o_foo_current, 0), o_err);
            bad++;
        end
    endtask

    task automatic test_reset_mid();
        i_rst_n = 1'b0;
        #1;
        total++;
        if (o_foo_next !== 32'h0) begin
            $display("[TB] FAIL mid_next: got %h want %h", o_foo_next, 32'h0);
            bad++;
        end
        step();
        i_rst_n = 1'b1;
        total++;
        if (o_foo_current !== 32'h0 || o_err !== 1'b0) begin
            $display("[TB] FAIL mid_cur: got cur=%h err=%b want cur=0 err=0", o_foo_current, o_err);
            bad++;
        end
        for (int c = 0; c < 5; c++) step();
        total++;
        if (o_foo_current !== 32'h0 || o_alloc_ready !== 1'b1 || o_alloc_slot !== 4'd0) begin
            $display("[TB] FAIL mid_idle: got cur=%h ready=%b slot=%0d want cur=0 ready=1 slot=0", o_foo_current, o_alloc_ready, o_alloc_slot);
            bad++;
        end
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_alloc_fill();
        test_lifecycle();
        test_drain_exit_no_grant();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
